fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 131 +++++++++++++
 tb/tb_fetch_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Memory fetch sequencer: optional address load, wait states, READY handshake with timeout abort.
// Latency: DONE in 2nd cycle after accepted START (3rd with JUMP) when WAIT_STATES=0 and READY=1.
// Backpressure: READY low stretches ADDR up to TIMEOUT_CYCLES samples; START ignored while BUSY.
module fetch_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       JUMP,
  input  logic [2:0] WAIT_STATES,
  input  logic       READY,
  input  logic [7:0] DATA_in,
  output logic       LOAD_bar,
  output logic       INC,
  output logic       ASSERT_bar,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT,
  output logic [7:0] DATA_out
);

  typedef enum logic [2:0] {IDLE, LOAD, ADDR, INCR, TOUT} state_t;

  // All strobes travel together so they are updated in lockstep with the state.
  typedef struct packed {
    logic load_bar;
    logic inc;
    logic assert_bar;
    logic busy;
    logic done;
    logic tout;
  } strobe_t;

  // Index of the last low READY sample that is still tolerated.
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  strobe_t    strb;
  logic [2:0] ws_lat;
  logic [2:0] wait_cnt;
  logic [7:0] tout_cnt;

  // Moore decode: strobe values belonging to a given state.
  function automatic strobe_t decode(input state_t s);
    strobe_t o;
    o = '{load_bar: 1'b1, inc: 1'b0, assert_bar: 1'b1, busy: 1'b1, done: 1'b0, tout: 1'b0};
    case (s)
      IDLE: o.busy = 1'b0;
      LOAD: o.load_bar = 1'b0;
      ADDR: o.assert_bar = 1'b0;
      INCR: begin
        o.inc  = 1'b1;
        o.done = 1'b1;
      end
      TOUT: o.tout = 1'b1;
      default: o.busy = 1'b0;
    endcase
    return o;
  endfunction

  // Strobes are registered together with the state, so they are glitch-free decodes of it.
  assign LOAD_bar   = strb.load_bar;
  assign INC        = strb.inc;
  assign ASSERT_bar = strb.assert_bar;
  assign BUSY       = strb.busy;
  assign DONE       = strb.done;
  assign TIMEOUT    = strb.tout;

  // Sequencer FSM: state, registered strobes, wait/timeout counters and read-data capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      strb     <= decode(IDLE);
      ws_lat   <= 3'd0;
      wait_cnt <= 3'd0;
      tout_cnt <= 8'd0;
      DATA_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            // Wait-state count is frozen here; later WAIT_STATES changes are ignored.
            ws_lat   <= WAIT_STATES;
            wait_cnt <= 3'd0;
            tout_cnt <= 8'd0;
            if (JUMP) begin
              state <= LOAD;
              strb  <= decode(LOAD);
            end else begin
              state <= ADDR;
              strb  <= decode(ADDR);
            end
          end
        end
        LOAD: begin
          wait_cnt <= 3'd0;
          tout_cnt <= 8'd0;
          state    <= ADDR;
          strb     <= decode(ADDR);
        end
        ADDR: begin
          if (wait_cnt < ws_lat) begin
            wait_cnt <= wait_cnt + 3'd1;
          end else if (READY) begin
            // READY wins even on the final timeout sample.
            DATA_out <= DATA_in;
            state    <= INCR;
            strb     <= decode(INCR);
          end else if (tout_cnt == TOUT_LAST) begin
            state <= TOUT;
            strb  <= decode(TOUT);
          end else begin
            tout_cnt <= tout_cnt + 8'd1;
          end
        end
        INCR, TOUT: begin
          wait_cnt <= 3'd0;
          tout_cnt <= 8'd0;
          state    <= IDLE;
          strb     <= decode(IDLE);
        end
        default: begin
          state <= IDLE;
          strb  <= decode(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, plain fetch, jump fetch, timeout, late READY, reset mid-fetch.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Strobe vector order: {LOAD_bar, INC, ASSERT_bar, BUSY, DONE, TIMEOUT}.
module tb_fetch_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       JUMP;
  logic [2:0] WAIT_STATES;
  logic       READY;
  logic [7:0] DATA_in;
  logic       LOAD_bar;
  logic       INC;
  logic       ASSERT_bar;
  logic       BUSY;
  logic       DONE;
  logic       TIMEOUT;
  logic [7:0] DATA_out;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] V_IDLE = 6'b101000;
  localparam logic [5:0] V_LOAD = 6'b001100;
  localparam logic [5:0] V_ADDR = 6'b100100;
  localparam logic [5:0] V_INCR = 6'b111110;
  localparam logic [5:0] V_TOUT = 6'b101101;

  fetch_seq #(.TIMEOUT_CYCLES(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .JUMP        (JUMP),
    .WAIT_STATES (WAIT_STATES),
    .READY       (READY),
    .DATA_in     (DATA_in),
    .LOAD_bar    (LOAD_bar),
    .INC         (INC),
    .ASSERT_bar  (ASSERT_bar),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .TIMEOUT     (TIMEOUT),
    .DATA_out    (DATA_out)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_strb(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {LOAD_bar, INC, ASSERT_bar, BUSY, DONE, TIMEOUT};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [7:0] exp);
    checks++;
    assert (DATA_out === exp) else begin
      errors++;
      $error("FAIL %s DATA_out observed=%h expected=%h", tag, DATA_out, exp);
    end
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; JUMP = 1'b0; WAIT_STATES = 3'd0; READY = 1'b0; DATA_in = 8'h00;

    // Reset pulse in mid-cycle, checked before any clock edge.
    #3 RST = 1'b1;
    #1;
    chk_strb("reset_async", V_IDLE);
    chk_data("reset_async", 8'h00);
    tick();
    RST = 1'b0;
    tick();
    chk_strb("idle_after_reset", V_IDLE);

    // Plain fetch.
    START = 1'b1; JUMP = 1'b0; WAIT_STATES = 3'd0; READY = 1'b1; DATA_in = 8'hA5;
    tick();
    START = 1'b0;
    chk_strb("plain_addr", V_ADDR);
    chk_data("plain_addr_hold", 8'h00);
    tick();
    chk_strb("plain_incr", V_INCR);
    chk_data("plain_capture", 8'hA5);
    tick();
    chk_strb("plain_idle", V_IDLE);

    // Jump fetch, two wait states; WAIT_STATES changed afterwards must not matter.
    START = 1'b1; JUMP = 1'b1; WAIT_STATES = 3'd2; READY = 1'b1; DATA_in = 8'h3C;
    tick();
    START = 1'b0; JUMP = 1'b0; WAIT_STATES = 3'd7;
    chk_strb("jump_load", V_LOAD);
    tick();
    chk_strb("jump_addr1", V_ADDR);
    chk_data("jump_addr1_hold", 8'hA5);
    tick();
    chk_strb("jump_addr2", V_ADDR);
    tick();
    chk_strb("jump_addr3", V_ADDR);
    tick();
    chk_strb("jump_incr", V_INCR);
    chk_data("jump_capture", 8'h3C);
    tick();
    chk_strb("jump_idle", V_IDLE);

    // Timeout: READY held low for all 16 samples.
    START = 1'b1; WAIT_STATES = 3'd0; READY = 1'b0; DATA_in = 8'hFF;
    tick();
    START = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_strb($sformatf("tout_addr%0d", i + 1), V_ADDR);
      tick();
    end
    chk_strb("tout_pulse", V_TOUT);
    chk_data("tout_data_kept", 8'h3C);
    tick();
    chk_strb("tout_idle", V_IDLE);

    // START held while busy, READY arrives on the 16th sample.
    START = 1'b1; READY = 1'b0; DATA_in = 8'h5A;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk_strb($sformatf("late_addr%0d", i + 1), V_ADDR);
      tick();
    end
    READY = 1'b1;
    chk_strb("late_addr16", V_ADDR);
    tick();
    START = 1'b0;
    chk_strb("late_incr", V_INCR);
    chk_data("late_capture", 8'h5A);
    tick();
    chk_strb("late_idle1", V_IDLE);
    tick();
    chk_strb("late_idle2_no_queue", V_IDLE);

    // Reset while the bus is driven.
    START = 1'b1; READY = 1'b0; DATA_in = 8'h11;
    tick();
    START = 1'b0;
    chk_strb("rst_mid_addr1", V_ADDR);
    tick();
    chk_strb("rst_mid_addr2", V_ADDR);
    #2 RST = 1'b1;
    #1;
    chk_strb("rst_mid_release", V_IDLE);
    chk_data("rst_mid_data", 8'h00);
    tick();
    RST = 1'b0;
    tick();
    chk_strb("rst_mid_after1", V_IDLE);
    tick();
    chk_strb("rst_mid_after2", V_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
